// File: rtl/compress_pkg.sv
// Shared types and default sizes for the compression front-end sequencer.
// Imported by the line controller and its test bench.
package compress_pkg;

    localparam int WIDTH_DEF      = 64;
    localparam int CACHE_LINE_DEF = 128;
    localparam int LATENCY_DEF    = 2;
    localparam int LEN_W_DEF      = 7;

    typedef enum logic [2:0] {
        IDLE,
        FEED0,
        FEED1,
        DRAIN,
        RESULT
    } state_e;

    typedef logic [LEN_W_DEF:0] len_t;

endpackage

// File: rtl/compress_line_ctrl_valid_delay.sv
// Fixed-depth 1-bit delay line, cleared asynchronously.
// Tracks word valids through the front-end pipeline.
module valid_delay #(
    parameter int DEPTH = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_valid,
    output logic o_valid
);

    logic [DEPTH-1:0] sr_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sr_q <= '0;
        end else begin
            sr_q[0] <= i_valid;
            for (int k = 1; k < DEPTH; k++) begin
                sr_q[k] <= sr_q[k-1];
            end
        end
    end

    assign o_valid = sr_q[DEPTH-1];

endmodule

// File: rtl/compress_line_ctrl.sv
// Line sequencer: splits a cache line into two words for the front end,
// sums the returned per-word lengths and reports the line result.
module compress_line_ctrl
    import compress_pkg::*;
#(
    parameter int WIDTH      = WIDTH_DEF,
    parameter int CACHE_LINE = CACHE_LINE_DEF,
    parameter int LATENCY    = LATENCY_DEF,
    parameter int LEN_W      = LEN_W_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_line_valid,
    output logic                  o_line_ready,
    input  logic [CACHE_LINE-1:0] i_line,
    output logic                  o_dict_clear,
    output logic [WIDTH-1:0]      o_word,
    output logic                  o_word_valid,
    input  logic [LEN_W-1:0]      i_total_length,
    output logic                  o_res_valid,
    input  logic                  i_res_ready,
    output logic [LEN_W:0]        o_comp_length,
    output logic                  o_uncompressible,
    output logic                  o_busy
);

    localparam logic [LEN_W:0] LIMIT = (LEN_W+1)'(CACHE_LINE);

    state_e                state_q;
    logic [CACHE_LINE-1:0] line_q;
    logic [LEN_W:0]        acc_q;
    logic [1:0]            cnt_q;
    logic [1:0]            cnt_d;
    logic                  tap;

    valid_delay #(
        .DEPTH(LATENCY)
    ) u_vdly (
        .i_clk  (i_clk),
        .i_rst_n(i_reset),
        .i_valid(o_word_valid),
        .o_valid(tap)
    );

    assign cnt_d = cnt_q + {1'b0, tap};

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= IDLE;
            line_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            if (tap) begin
                acc_q <= acc_q + {1'b0, i_total_length};
                cnt_q <= cnt_d;
            end
            unique case (state_q)
                IDLE: begin
                    if (i_line_valid) begin
                        line_q  <= i_line;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= FEED0;
                    end
                end
                FEED0:  state_q <= FEED1;
                FEED1:  state_q <= DRAIN;
                // leave as the second length is being summed
                DRAIN: begin
                    if (cnt_d == 2'd2) state_q <= RESULT;
                end
                RESULT: begin
                    if (i_res_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        o_word       = '0;
        o_word_valid = 1'b0;
        unique case (state_q)
            FEED0: begin
                o_word       = line_q[WIDTH-1:0];
                o_word_valid = 1'b1;
            end
            FEED1: begin
                o_word       = line_q[2*WIDTH-1:WIDTH];
                o_word_valid = 1'b1;
            end
            default: ;
        endcase
    end

    assign o_line_ready     = (state_q == IDLE);
    assign o_dict_clear     = (state_q == IDLE) && i_line_valid;
    assign o_res_valid      = (state_q == RESULT);
    assign o_busy           = (state_q != IDLE);
    assign o_comp_length    = acc_q;
    assign o_uncompressible = (acc_q > LIMIT);

endmodule

// File: tb/tb_compress_line_ctrl.sv
// Bench for compress_line_ctrl: front-end stub plus directed and random
// lines checked against the expected per-line sums and cycle timing.
module tb_compress_line_ctrl;
    import compress_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         i_line_valid;
    logic         o_line_ready;
    logic [127:0] i_line;
    logic         o_dict_clear;
    logic [63:0]  o_word;
    logic         o_word_valid;
    logic [6:0]   i_total_length;
    logic         o_res_valid;
    logic         i_res_ready;
    logic [7:0]   o_comp_length;
    logic         o_uncompressible;
    logic         o_busy;

    int n_cmp = 0;
    int n_bad = 0;

    logic [6:0] len0, len1, stray;
    logic [2:0] w;
    logic       k;

    always #5 clk = ~clk;

    compress_line_ctrl dut (
        .i_clk           (clk),
        .i_reset         (rst_n),
        .i_line_valid    (i_line_valid),
        .o_line_ready    (o_line_ready),
        .i_line          (i_line),
        .o_dict_clear    (o_dict_clear),
        .o_word          (o_word),
        .o_word_valid    (o_word_valid),
        .i_total_length  (i_total_length),
        .o_res_valid     (o_res_valid),
        .i_res_ready     (i_res_ready),
        .o_comp_length   (o_comp_length),
        .o_uncompressible(o_uncompressible),
        .o_busy          (o_busy)
    );

    // Front-end stub: answers each issued word two cycles later.
    always @(negedge clk) begin
        if (!rst_n) begin
            w = 3'b000;
            k = 1'b0;
            i_total_length = stray;
        end else begin
            w = {w[1:0], o_word_valid};
            if (w[2]) begin
                i_total_length = k ? len1 : len0;
                k = ~k;
            end else begin
                i_total_length = stray;
            end
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rnd_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic do_line(input logic [127:0] ln, input logic [6:0] a,
                           input logic [6:0] b, input int hold);
        len_t sum;
        logic unc;
        sum = len_t'(a) + len_t'(b);
        unc = (int'(sum) > 128);
        len0 = a;
        len1 = b;
        i_line = ln;
        i_line_valid = 1'b1;
        i_res_ready = 1'b0;
        #1;
        chk("acc_ready", 128'(o_line_ready), 128'(1));
        chk("acc_clear", 128'(o_dict_clear), 128'(1));
        chk("acc_wvalid", 128'(o_word_valid), 128'(0));
        chk("acc_busy", 128'(o_busy), 128'(0));
        tick();
        i_line = rnd_line();
        i_res_ready = 1'b1;
        #1;
        chk("w0_word", 128'(o_word), 128'(ln[63:0]));
        chk("w0_valid", 128'(o_word_valid), 128'(1));
        chk("w0_clear", 128'(o_dict_clear), 128'(0));
        chk("w0_ready", 128'(o_line_ready), 128'(0));
        chk("w0_busy", 128'(o_busy), 128'(1));
        tick();
        i_line = rnd_line();
        #1;
        chk("w1_word", 128'(o_word), 128'(ln[127:64]));
        chk("w1_valid", 128'(o_word_valid), 128'(1));
        chk("w1_clear", 128'(o_dict_clear), 128'(0));
        tick();
        #1;
        chk("d0_valid", 128'(o_word_valid), 128'(0));
        chk("d0_word", 128'(o_word), 128'(0));
        chk("d0_res", 128'(o_res_valid), 128'(0));
        tick();
        #1;
        chk("d1_res", 128'(o_res_valid), 128'(0));
        tick();
        i_res_ready = (hold == 0);
        if (hold == 0) i_line_valid = 1'b0;
        #1;
        chk("res_valid", 128'(o_res_valid), 128'(1));
        chk("res_len", 128'(o_comp_length), 128'(sum));
        chk("res_unc", 128'(o_uncompressible), 128'(unc));
        chk("res_ready", 128'(o_line_ready), 128'(0));
        for (int h = 0; h < hold; h++) begin
            if (h > 0) tick();
            i_line = rnd_line();
            #1;
            chk("hold_valid", 128'(o_res_valid), 128'(1));
            chk("hold_len", 128'(o_comp_length), 128'(sum));
            chk("hold_unc", 128'(o_uncompressible), 128'(unc));
            chk("hold_lready", 128'(o_line_ready), 128'(0));
            chk("hold_clear", 128'(o_dict_clear), 128'(0));
        end
        if (hold > 0) begin
            tick();
            i_line_valid = 1'b0;
            i_res_ready = 1'b1;
            #1;
            chk("pulse_valid", 128'(o_res_valid), 128'(1));
        end
        tick();
        i_res_ready = 1'b0;
        #1;
        chk("idle_ready", 128'(o_line_ready), 128'(1));
        chk("idle_busy", 128'(o_busy), 128'(0));
        chk("idle_res", 128'(o_res_valid), 128'(0));
    endtask

    initial begin
        rst_n = 1'b0;
        i_line_valid = 1'b0;
        i_line = '0;
        i_res_ready = 1'b0;
        len0 = '0;
        len1 = '0;
        stray = 7'd99;
        tick();
        chk("rst_ready", 128'(o_line_ready), 128'(1));
        chk("rst_busy", 128'(o_busy), 128'(0));
        chk("rst_wvalid", 128'(o_word_valid), 128'(0));
        chk("rst_res", 128'(o_res_valid), 128'(0));
        chk("rst_len", 128'(o_comp_length), 128'(0));
        chk("rst_clear", 128'(o_dict_clear), 128'(0));
        tick();
        rst_n = 1'b1;
        tick();

        do_line(128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF, 7'd20, 7'd30, 0);
        do_line(rnd_line(), 7'd64, 7'd64, 5);
        do_line(rnd_line(), 7'd68, 7'd68, 0);
        do_line(rnd_line(), 7'd65, 7'd64, 0);

        // Reset while draining, then a stray length that must be ignored.
        stray = 7'd40;
        len0 = 7'd33;
        len1 = 7'd44;
        i_line = rnd_line();
        i_line_valid = 1'b1;
        tick();
        i_line_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 128'(o_line_ready), 128'(1));
        chk("mid_rst_busy", 128'(o_busy), 128'(0));
        chk("mid_rst_len", 128'(o_comp_length), 128'(0));
        chk("mid_rst_res", 128'(o_res_valid), 128'(0));
        chk("mid_rst_wv", 128'(o_word_valid), 128'(0));
        tick();
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        chk("post_rst_len", 128'(o_comp_length), 128'(0));
        chk("post_rst_busy", 128'(o_busy), 128'(0));
        do_line(rnd_line(), 7'd10, 7'd15, 0);

        for (int i = 0; i < 12; i++) begin
            stray = 7'($urandom);
            do_line(rnd_line(), 7'($urandom_range(0, 68)),
                    7'($urandom_range(0, 68)), (i % 4 == 3) ? 2 : 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
